// File: rtl/encmem_pkg.sv
// Shared geometry, mask table and FSM state encoding for the encoded difference memory.
package encmem_pkg;

    localparam int unsigned ENCMEM_DEPTH = 8;
    localparam int unsigned ENCMEM_AW    = 3;
    localparam int unsigned ENCMEM_DW    = 8;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    function automatic logic [ENCMEM_DW-1:0] encmem_mask(input logic [ENCMEM_AW-1:0] idx);
        logic [ENCMEM_DW-1:0] m;
        unique case (idx)
            3'd0:    m = 8'h00;
            3'd1:    m = 8'h55;
            3'd2:    m = 8'hAA;
            3'd3:    m = 8'h33;
            3'd4:    m = 8'hCC;
            3'd5:    m = 8'h0F;
            3'd6:    m = 8'hF0;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/encmem_core.sv
// 8x8 storage holding |number - mask[index]| per entry; single write/read port,
// registered read data, clear path writes zero.
module encmem_core
    import encmem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr,
    input  logic                 clr,
    input  logic [ENCMEM_AW-1:0] addr,
    input  logic [ENCMEM_DW-1:0] number,
    output logic [ENCMEM_DW-1:0] rdata
);

    logic [ENCMEM_DW-1:0] mem [ENCMEM_DEPTH];
    logic [ENCMEM_DW-1:0] mask;
    logic [ENCMEM_DW-1:0] wdata;

    always_comb begin
        mask  = encmem_mask(addr);
        wdata = (number > mask) ? (number - mask) : (mask - number);
        if (clr) begin
            wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENCMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (wr) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/encmem_arbiter.sv
// Round-robin two-client front end for encmem_core with per-client read return.
// Optional hardware clear sweep enabled by defining ENCMEM_CLEAR_EN.
module encmem_arbiter
    import encmem_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
`ifdef ENCMEM_CLEAR_EN
    input  logic                 clr_req,
    output logic                 clr_busy,
`endif
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 mode0,
    input  logic                 mode1,
    input  logic [ENCMEM_AW-1:0] index0,
    input  logic [ENCMEM_AW-1:0] index1,
    input  logic [ENCMEM_DW-1:0] number0,
    input  logic [ENCMEM_DW-1:0] number1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [ENCMEM_DW-1:0] result0,
    output logic [ENCMEM_DW-1:0] result1
);

    state_t               state;
    logic [ENCMEM_AW-1:0] sweep_idx;
    logic                 prio;
    logic                 serve;
    logic                 clearing;
    logic                 core_en;
    logic                 core_wr;
    logic [ENCMEM_AW-1:0] core_addr;
    logic [ENCMEM_DW-1:0] core_number;
    logic [ENCMEM_DW-1:0] rdata;
    logic [ENCMEM_DW-1:0] hold0;
    logic [ENCMEM_DW-1:0] hold1;

`ifdef ENCMEM_CLEAR_EN
    state_t               state_nxt;
    logic [ENCMEM_AW-1:0] sweep;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                sweep <= sweep + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
            ST_CLEAR: if (sweep == ENCMEM_AW'(ENCMEM_DEPTH - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb sweep_idx = sweep;
`else
    always_comb begin
        state     = ST_IDLE;
        sweep_idx = '0;
    end
`endif

    always_comb begin
        clearing = (state == ST_CLEAR);
        serve    = (state == ST_IDLE);
`ifdef ENCMEM_CLEAR_EN
        // The accept cycle issues no grant so the clear wins over pending requests.
        serve    = serve && !clr_req;
        clr_busy = clearing;
`endif
        gnt0        = serve && req0 && (!req1 || !prio);
        gnt1        = serve && req1 && (!req0 || prio);
        core_en     = gnt0 || gnt1 || clearing;
        core_wr     = !mode0;
        core_addr   = index0;
        core_number = number0;
        if (clearing) begin
            core_wr   = 1'b1;
            core_addr = sweep_idx;
        end else if (gnt1) begin
            core_wr     = !mode1;
            core_addr   = index1;
            core_number = number1;
        end
    end

    encmem_core u_core (
        .clk    (CLK),
        .rst    (RST),
        .en     (core_en),
        .wr     (core_wr),
        .clr    (clearing),
        .addr   (core_addr),
        .number (core_number),
        .rdata  (rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            prio    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
            rvalid0 <= gnt0 && mode0;
            rvalid1 <= gnt1 && mode1;
            if (rvalid0) hold0 <= rdata;
            if (rvalid1) hold1 <= rdata;
        end
    end

    // The core's read register is shared; each client keeps its own copy once the pulse ends.
    always_comb begin
        result0 = rvalid0 ? rdata : hold0;
        result1 = rvalid1 ? rdata : hold1;
    end

endmodule
